// File: rtl/efpga_cfg_pkg.sv
// Shared types and defaults for the eFPGA configuration frame loader.
// Holds the loader state encoding, the default sync/pad words and the frame counter width.
package efpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CHECK,
        ST_STROBE
    } cfg_state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DEFAULT_PAD_PATTERN = 32'h1234_5678;
    localparam int          FRAMES_WRITTEN_W    = 16;

endpackage

// File: rtl/cfg_xor_checksum.sv
// Running XOR over one frame (address word + row words), compared against a trailing checksum word.
// Seed loads, accum folds in, clear zeroes; match is combinational against the presented word.
module cfg_xor_checksum (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        seed,
    input  logic        accum,
    input  logic [31:0] data,
    output logic [31:0] sum,
    output logic        match
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= '0;
        end else if (seed) begin
            sum <= data;
        end else if (accum) begin
            sum <= sum ^ data;
        end
    end

    assign match = (sum == data);

endmodule

// File: rtl/efpga_frame_loader.sv
// Stream-fed eFPGA frame loader: sync word, frame address, one word per row, optional XOR check, strobe.
// Strobe one cycle after last row/checksum word; in_ready low during the strobe cycle and while abort is high.
module efpga_frame_loader
    import efpga_cfg_pkg::*;
#(
    parameter int          NumberOfRows    = 16,
    parameter int          FrameBitsPerRow = 32,
    parameter int          RowSelectWidth  = 5,
    parameter int          DesyncFlag      = 20,
    parameter logic [31:0] SyncWord        = DEFAULT_SYNC_WORD,
    parameter logic [31:0] PadPattern      = DEFAULT_PAD_PATTERN,
    parameter bit          ChecksumEnable  = 1'b0
) (
    input  logic                                        CLK,
    input  logic                                        reset,
    input  logic [31:0]                                 in_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        abort,
    output logic [FrameBitsPerRow-1:0]                  FrameAddressRegister,
    output logic                                        LongFrameStrobe,
    output logic [FrameBitsPerRow*(NumberOfRows+2)-1:0] FrameData,
    output logic                                        ConfigActive,
    output logic                                        ChecksumError,
    output logic [FRAMES_WRITTEN_W-1:0]                 FramesWritten
);

    localparam logic [FrameBitsPerRow-1:0] PadRow  = PadPattern[FrameBitsPerRow-1:0];
    localparam logic [RowSelectWidth-1:0]  LastRow = RowSelectWidth'(NumberOfRows - 1);

    cfg_state_t                  state;
    logic [RowSelectWidth-1:0]   row_cnt;
    logic [FrameBitsPerRow-1:0]  rows [NumberOfRows];
    logic                        fire;
    logic                        ck_match;
    logic [31:0]                 ck_sum;

    assign in_ready     = !reset && !abort && (state != ST_STROBE);
    assign fire         = in_valid && in_ready;
    assign ConfigActive = (state != ST_IDLE);

    cfg_xor_checksum u_checksum (
        .clk   (CLK),
        .reset (reset),
        .clear (abort),
        .seed  (fire && (state == ST_ADDR) && !in_data[DesyncFlag]),
        .accum (fire && (state == ST_DATA)),
        .data  (in_data),
        .sum   (ck_sum),
        .match (ck_match)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state                <= ST_IDLE;
            row_cnt              <= '0;
            FrameAddressRegister <= '0;
            LongFrameStrobe      <= 1'b0;
            ChecksumError        <= 1'b0;
            FramesWritten        <= '0;
            for (int r = 0; r < NumberOfRows; r++) rows[r] <= '0;
        end else begin
            LongFrameStrobe <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fire && in_data == SyncWord) begin
                            state         <= ST_ADDR;
                            ChecksumError <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        if (fire) begin
                            if (in_data[DesyncFlag]) begin
                                state <= ST_IDLE;
                            end else begin
                                FrameAddressRegister <= in_data[FrameBitsPerRow-1:0];
                                row_cnt              <= '0;
                                state                <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (fire) begin
                            // Compare-per-row keeps every write inside the row array.
                            for (int r = 0; r < NumberOfRows; r++) begin
                                if (row_cnt == RowSelectWidth'(r)) rows[r] <= in_data[FrameBitsPerRow-1:0];
                            end
                            row_cnt <= row_cnt + 1'b1;
                            if (row_cnt == LastRow) begin
                                if (ChecksumEnable) begin
                                    state <= ST_CHECK;
                                end else begin
                                    state           <= ST_STROBE;
                                    LongFrameStrobe <= 1'b1;
                                    if (FramesWritten != '1) FramesWritten <= FramesWritten + 1'b1;
                                end
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (fire) begin
                            if (ck_match) begin
                                state           <= ST_STROBE;
                                LongFrameStrobe <= 1'b1;
                                if (FramesWritten != '1) FramesWritten <= FramesWritten + 1'b1;
                            end else begin
                                ChecksumError <= 1'b1;
                                state         <= ST_ADDR;
                            end
                        end
                    end
                    ST_STROBE: state <= ST_ADDR;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        FrameData = '0;
        FrameData[FrameBitsPerRow-1:0] = PadRow;
        for (int r = 0; r < NumberOfRows; r++) begin
            FrameData[FrameBitsPerRow*(r+1) +: FrameBitsPerRow] = rows[r];
        end
        FrameData[FrameBitsPerRow*(NumberOfRows+1) +: FrameBitsPerRow] = PadRow;
    end

endmodule
